interface_adapter_via: RTL and testbench

Memory-mapped parallel I/O adapter for the 6502 system, modelled on the port section of a 6522 VIA. It occupies a 16-byte window (CPU addresses 0x0800–0x080F) and exposes two 8-bit ports, A and B, each with a per-bit data-direction register. The CPU reaches it through a 4-bit register select and a chip enable. There is no read/write strobe, so register roles are split by address.

---
 rtl/interface_adapter_via.sv | 85 ++++++++
 tb/tb_interface_adapter_via.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/interface_adapter_via.sv
// Port section of a 6522-style VIA: two 8-bit ports with per-bit direction registers.
// The bus has no R/W strobe, so any enabled access to 0x2-0x5 is treated as a store.
module interface_adapter_via (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_a_in,
   output logic [7:0] port_a_out,
   input  logic [7:0] port_b_in,
   output logic [7:0] port_b_out,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic [3:0] register_select,
   input  logic       chip_en
);

   localparam logic [3:0] REG_IRB  = 4'h0;
   localparam logic [3:0] REG_IRA  = 4'h1;
   localparam logic [3:0] REG_DDRB = 4'h2;
   localparam logic [3:0] REG_DDRA = 4'h3;
   localparam logic [3:0] REG_ORB  = 4'h4;
   localparam logic [3:0] REG_ORA  = 4'h5;

   logic [7:0] ddra, ddrb, ora, orb;
   logic [7:0] ddra_next, ddrb_next, ora_next, orb_next;
   logic [7:0] sync_a_meta, sync_a, sync_b_meta, sync_b;

   always_comb begin
      ddra_next = ddra;
      ddrb_next = ddrb;
      ora_next  = ora;
      orb_next  = orb;
      if (chip_en) begin
         case (register_select)
            REG_DDRB: ddrb_next = data_in;
            REG_DDRA: ddra_next = data_in;
            REG_ORB:  orb_next  = data_in;
            REG_ORA:  ora_next  = data_in;
            default: ;
         endcase
      end
   end

   // Pins are registered from the next-state values so they move on the write edge itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ddra        <= 8'h00;
         ddrb        <= 8'h00;
         ora         <= 8'h00;
         orb         <= 8'h00;
         sync_a_meta <= 8'h00;
         sync_a      <= 8'h00;
         sync_b_meta <= 8'h00;
         sync_b      <= 8'h00;
         port_a_out  <= 8'h00;
         port_b_out  <= 8'h00;
      end else begin
         ddra        <= ddra_next;
         ddrb        <= ddrb_next;
         ora         <= ora_next;
         orb         <= orb_next;
         sync_a_meta <= port_a_in;
         sync_a      <= sync_a_meta;
         sync_b_meta <= port_b_in;
         sync_b      <= sync_b_meta;
         port_a_out  <= ora_next & ddra_next;
         port_b_out  <= orb_next & ddrb_next;
      end
   end

   always_comb begin
      data_out = 8'h00;
      if (chip_en) begin
         case (register_select)
            REG_IRB:  data_out = (port_b_out & ddrb) | (sync_b & ~ddrb);
            REG_IRA:  data_out = (port_a_out & ddra) | (sync_a & ~ddra);
            REG_DDRB: data_out = ddrb;
            REG_DDRA: data_out = ddra;
            REG_ORB:  data_out = orb;
            REG_ORA:  data_out = ora;
            default:  data_out = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_interface_adapter_via.sv
// Self-checking bench for interface_adapter_via: directed scenarios plus random
// accesses checked against a register-map reference model.
module tb_interface_adapter_via;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_a_in, port_a_out, port_b_in, port_b_out;
   logic [7:0] data_in, data_out;
   logic [3:0] register_select;
   logic       chip_en;

   int checks = 0;
   int failures = 0;

   interface_adapter_via dut (
      .clk(clk), .reset(reset),
      .port_a_in(port_a_in), .port_a_out(port_a_out),
      .port_b_in(port_b_in), .port_b_out(port_b_out),
      .data_in(data_in), .data_out(data_out),
      .register_select(register_select), .chip_en(chip_en)
   );

   always #5 clk = ~clk;

   // Reference model: register file plus history of pin values seen at each edge.
   logic [7:0] m_reg [16];
   logic [7:0] hist_a [$];
   logic [7:0] hist_b [$];

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
      hist_a.delete();
      hist_b.delete();
   endfunction

   // Input register sees the pin level from two edges back.
   function automatic logic [7:0] m_pin(input logic is_a);
      if (is_a) return (hist_a.size() >= 2) ? hist_a[hist_a.size()-2] : 8'h00;
      else      return (hist_b.size() >= 2) ? hist_b[hist_b.size()-2] : 8'h00;
   endfunction

   function automatic logic [7:0] m_out_a();
      return m_reg[5] & m_reg[3];
   endfunction

   function automatic logic [7:0] m_out_b();
      return m_reg[4] & m_reg[2];
   endfunction

   function automatic logic [7:0] m_read(input logic ce, input logic [3:0] rs);
      if (!ce) return 8'h00;
      case (rs)
         4'h0: return (m_out_b() & m_reg[2]) | (m_pin(1'b0) & ~m_reg[2]);
         4'h1: return (m_out_a() & m_reg[3]) | (m_pin(1'b1) & ~m_reg[3]);
         4'h2, 4'h3, 4'h4, 4'h5: return m_reg[rs];
         default: return 8'h00;
      endcase
   endfunction

   // One bus cycle: drive at negedge, let the edge happen, update the model, settle.
   task automatic step(input logic ce, input logic [3:0] rs, input logic [7:0] din);
      @(negedge clk);
      chip_en = ce;
      register_select = rs;
      data_in = din;
      @(posedge clk);
      if (reset) m_reset();
      else begin
         if (ce && rs >= 4'h2 && rs <= 4'h5) m_reg[rs] = din;
         hist_a.push_back(port_a_in);
         hist_b.push_back(port_b_in);
         if (hist_a.size() > 2) void'(hist_a.pop_front());
         if (hist_b.size() > 2) void'(hist_b.pop_front());
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      chip_en = 1'b1; register_select = 4'h4; data_in = 8'hFF;
      port_a_in = 8'h00; port_b_in = 8'h00;
      m_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         port_a_in = ~port_a_in;
         port_b_in = 8'h5A ^ port_b_in;
      end
      #1;
      checks++;
      if (port_a_out !== 8'h00) begin failures++; $display("FAIL reset_port_a got=%h exp=00", port_a_out); end
      checks++;
      if (port_b_out !== 8'h00) begin failures++; $display("FAIL reset_port_b got=%h exp=00", port_b_out); end
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
      @(negedge clk);
      reset = 1'b0;
      port_a_in = 8'h00; port_b_in = 8'h00;
      for (int r = 0; r < 16; r++) begin
         step(1'b1, r[3:0], 8'h00);
         checks++;
         if (data_out !== 8'h00) begin failures++; $display("FAIL reset_read_%0d got=%h exp=00", r, data_out); end
      end
   endtask

   task automatic test_output_drive();
      step(1'b1, 4'h2, 8'hFF);
      step(1'b1, 4'h4, 8'hA5);
      checks++;
      if (port_b_out !== 8'hA5) begin failures++; $display("FAIL drive_port_b got=%h exp=a5", port_b_out); end
      step(1'b1, 4'h0, 8'h00);
      checks++;
      if (data_out !== 8'hA5) begin failures++; $display("FAIL drive_irb got=%h exp=a5", data_out); end
   endtask

   task automatic test_mixed_direction();
      port_a_in = 8'h3C;
      step(1'b1, 4'h3, 8'hF0);
      step(1'b1, 4'h5, 8'hFF);
      checks++;
      if (port_a_out !== 8'hF0) begin failures++; $display("FAIL mixed_port_a got=%h exp=f0", port_a_out); end
      step(1'b1, 4'h1, 8'h00);
      checks++;
      if (data_out !== 8'hFC) begin failures++; $display("FAIL mixed_ira got=%h exp=fc", data_out); end
   endtask

   task automatic test_input_latency();
      port_b_in = 8'h00;
      step(1'b1, 4'h2, 8'h00);
      step(1'b0, 4'h0, 8'h00);
      step(1'b0, 4'h0, 8'h00);
      port_b_in = 8'hFF;
      step(1'b1, 4'h0, 8'h00);
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL latency_1edge got=%h exp=00", data_out); end
      step(1'b1, 4'h0, 8'h00);
      checks++;
      if (data_out !== 8'hFF) begin failures++; $display("FAIL latency_2edge got=%h exp=ff", data_out); end
   endtask

   task automatic test_decode();
      step(1'b1, 4'h2, 8'hFF);
      step(1'b1, 4'h4, 8'hA5);
      step(1'b0, 4'h4, 8'h55);
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL decode_ce_low got=%h exp=00", data_out); end
      checks++;
      if (port_b_out !== 8'hA5) begin failures++; $display("FAIL decode_orb_kept got=%h exp=a5", port_b_out); end
      step(1'b1, 4'h9, 8'h77);
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL decode_reg9 got=%h exp=00", data_out); end
      checks++;
      if (port_b_out !== 8'hA5) begin failures++; $display("FAIL decode_reg9_side got=%h exp=a5", port_b_out); end
      step(1'b1, 4'h0, 8'h00);
      checks++;
      if (data_out !== 8'hA5) begin failures++; $display("FAIL decode_irb got=%h exp=a5", data_out); end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 4'h2, 8'h0F);
      step(1'b1, 4'h3, 8'h3C);
      step(1'b1, 4'h4, 8'hFF);
      step(1'b1, 4'h5, 8'hAA);
      checks++;
      if (port_a_out !== 8'h28) begin failures++; $display("FAIL b2b_port_a got=%h exp=28", port_a_out); end
      checks++;
      if (port_b_out !== 8'h0F) begin failures++; $display("FAIL b2b_port_b got=%h exp=0f", port_b_out); end
   endtask

   task automatic test_async_reset();
      step(1'b1, 4'h2, 8'hFF);
      step(1'b1, 4'h4, 8'hA5);
      checks++;
      if (port_b_out !== 8'hA5) begin failures++; $display("FAIL async_pre got=%h exp=a5", port_b_out); end
      @(negedge clk);
      register_select = 4'h5; data_in = 8'hEE;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (port_b_out !== 8'h00) begin failures++; $display("FAIL async_port_b got=%h exp=00", port_b_out); end
      reset = 1'b0;
      m_reset();
      #1;
      checks++;
      if (port_a_out !== 8'h00) begin failures++; $display("FAIL async_port_a got=%h exp=00", port_a_out); end
      step(1'b1, 4'h2, 8'h00);
      step(1'b1, 4'h5, 8'h33);
      checks++;
      if (data_out !== 8'h33) begin failures++; $display("FAIL async_post_write got=%h exp=33", data_out); end
   endtask

   task automatic test_random();
      logic       ce;
      logic [3:0] rs;
      for (int i = 0; i < 400; i++) begin
         port_a_in = 8'($urandom);
         port_b_in = 8'($urandom);
         ce = ($urandom_range(0, 3) != 0);
         rs = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom);
         step(ce, rs, 8'($urandom));
         checks++;
         if (data_out !== m_read(ce, rs)) begin
            failures++;
            $display("FAIL rand_read i=%0d rs=%h got=%h exp=%h", i, rs, data_out, m_read(ce, rs));
         end
         checks++;
         if (port_a_out !== m_out_a()) begin
            failures++; $display("FAIL rand_port_a i=%0d got=%h exp=%h", i, port_a_out, m_out_a());
         end
         checks++;
         if (port_b_out !== m_out_b()) begin
            failures++; $display("FAIL rand_port_b i=%0d got=%h exp=%h", i, port_b_out, m_out_b());
         end
      end
   endtask

   initial begin
      test_reset();
      test_output_drive();
      test_mixed_direction();
      test_input_latency();
      test_decode();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
